// File: rtl/multi_colour_detect.sv
// multi_colour_detect: per-frame RGB box match counters with end-of-frame latch and short-frame detection.
// Optional left/centre/right split per channel when MULTI_COLOUR_REGION_SPLIT_EN is defined.
module multi_colour_detect #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int NUM_CH     = 3,
    parameter int PIX_W      = 4,
    parameter int SCREEN_PCT = 80,
    localparam int TOTAL     = IMG_W * IMG_H,
    localparam int CW        = $clog2(TOTAL + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid,
    input  logic [3*PIX_W-1:0]        pix_data,
    input  logic                      sop,
    input  logic [NUM_CH*3*PIX_W-1:0] ch_lo,
    input  logic [NUM_CH*3*PIX_W-1:0] ch_hi,
    output logic [NUM_CH*CW-1:0]      count_out,
    output logic [NUM_CH-1:0]         flag,
    output logic                      frame_done,
    output logic                      frame_err
`ifdef MULTI_COLOUR_REGION_SPLIT_EN
    ,
    output logic [NUM_CH*3*CW-1:0]    region_out
`endif
);

    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] THRESH   = CW'((TOTAL * SCREEN_PCT) / 100);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     pix_cnt;
    logic [CW-1:0]     idx;
    logic [NUM_CH-1:0] hit;
    logic              accept;
    logic              start;
    logic              last;
    logic              early;
    logic [CW-1:0]     cnt     [NUM_CH];
    logic [CW-1:0]     cnt_new [NUM_CH];

    // Valid-only stream: a pixel transfers on every edge with pix_valid=1; there is no back-pressure.
    always_comb begin
        hit = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (pix_data[k*PIX_W +: PIX_W] < ch_lo[(c*3+k)*PIX_W +: PIX_W] ||
                    pix_data[k*PIX_W +: PIX_W] > ch_hi[(c*3+k)*PIX_W +: PIX_W])
                    hit[c] = 1'b0;
            end
        end
    end

    // A sop pixel always restarts the frame at index 0, whichever state we are in.
    assign start  = pix_valid && sop;
    assign accept = pix_valid && (sop || state == ACTIVE);
    assign idx    = start ? '0 : pix_cnt;
    assign last   = accept && (idx == LAST_IDX);
    assign early  = start && (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (accept)
            state_next = last ? IDLE : ACTIVE;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            cnt_new[c] = (start ? '0 : cnt[c]) + CW'(hit[c]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt    <= '0;
            count_out  <= '0;
            flag       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                cnt[c] <= '0;
        end else begin
            frame_done <= last;
            frame_err  <= early;
            if (accept) begin
                if (last) begin
                    pix_cnt <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        cnt[c]                 <= '0;
                        count_out[c*CW +: CW]  <= cnt_new[c];
                        flag[c]                <= (cnt_new[c] > THRESH);
                    end
                end else begin
                    pix_cnt <= idx + CW'(1);
                    for (int c = 0; c < NUM_CH; c++)
                        cnt[c] <= cnt_new[c];
                end
            end
        end
    end

`ifdef MULTI_COLOUR_REGION_SPLIT_EN
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [XW-1:0] L_END = XW'(IMG_W / 3);
    localparam logic [XW-1:0] C_END = XW'((2 * IMG_W) / 3);

    logic [XW-1:0] x;
    logic [XW-1:0] x_cur;
    logic [XW-1:0] x_next;
    logic [1:0]    rsel;
    logic [CW-1:0] reg_cnt [NUM_CH][3];
    logic [CW-1:0] reg_new [NUM_CH][3];

    assign x_cur  = start ? '0 : x;
    assign x_next = (x_cur == X_MAX) ? '0 : x_cur + XW'(1);

    // rsel: 0 = left, 1 = centre, 2 = right column band
    always_comb begin
        if (x_cur < L_END)      rsel = 2'd0;
        else if (x_cur < C_END) rsel = 2'd1;
        else                    rsel = 2'd2;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 3; r++)
                reg_new[c][r] = (start ? '0 : reg_cnt[c][r]) + CW'(hit[c] && (rsel == 2'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            region_out <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int r = 0; r < 3; r++)
                    reg_cnt[c][r] <= '0;
        end else if (accept) begin
            if (last) begin
                x <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int r = 0; r < 3; r++) begin
                        reg_cnt[c][r]                  <= '0;
                        region_out[(c*3+r)*CW +: CW]   <= reg_new[c][r];
                    end
                end
            end else begin
                x <= x_next;
                for (int c = 0; c < NUM_CH; c++)
                    for (int r = 0; r < 3; r++)
                        reg_cnt[c][r] <= reg_new[c][r];
            end
        end
    end
`endif

endmodule
